divider: RTL
============

// Module: divider
// PURPOSE
//  Multi-cycle 32-bit integer divider: the inverse of the Booth multiplier in the MULT/DIV unit.
//  Takes dividend A and divisor B on a start pulse and runs one restoring step per clock.
//  Writes the quotient to Lo and the remainder to Hi (MIPS DIV semantics), then pulses done.
//  Control unit holds the datapath while busy.
// PARAMETERS
//  WIDTH   32   operand/result width; step counter is $clog2(WIDTH)+1 bits
// PORTS
//  clk       in   1      clock, rising edge
//  reset     in   1      asynchronous, active-low; all state cleared while low
//  start     in   1      1-cycle request; samples A, B on the same edge
//  A         in   WIDTH  dividend
//  B         in   WIDTH  divisor
//  Hi        out  WIDTH  remainder, registered
//  Lo        out  WIDTH  quotient, registered
//  busy      out  1      high from the edge after start until the edge that raises done
//  done      out  1      1-cycle pulse when Hi/Lo update
//  div0      out  1      sticky until the next start: last op had B==0
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; Hi, Lo=0; busy, done, div0=0; counter=0.
//  States: IDLE -> ITER (WIDTH cycles) -> FIX -> IDLE; IDLE -> ZDIV -> IDLE when B==0.
//  Edge with start=1, any state:
//   - latch |A|, |B| and the sign flags sq=A[31]^B[31], sr=A[31]
//   - R=0, counter=WIDTH, clear div0
//   - next state is ITER, or ZDIV if B==0
//  A start during ITER/FIX aborts the running op and restarts it; no done for the aborted op.
//  ITER, each edge:
//   - {R,Q} <<= 1; if R >= |B| then R -= |B| and Q[0] = 1
//   - counter--; at counter==1, next state is FIX
//  FIX edge:
//   - Lo = sq ? -Q : Q; Hi = sr ? -R : R
//   - done=1 for exactly this cycle; busy=0
//  Latency: done is high WIDTH+1 cycles after the start edge (33 at default).
//  Result rules:
//   - quotient truncates toward zero; remainder takes the sign of the dividend
//   - -2^31 / -1 gives Lo=32'h80000000, Hi=0 (wraps, no flag)
//  ZDIV edge: Hi=A (the latched raw value), Lo=all-ones, div0=1, done pulse. Latency is 1 cycle.
//  Outside the update edges Hi/Lo hold their value. done is never high while busy is high.
//  Arithmetic: R and the compare use WIDTH+1 bits so |B|=2^31 does not overflow.
// CONFIGURATION
//  DIVIDER_UNSIGNED_EN defined:
//   - adds input port unsigned_op (1 bit), sampled with start
//   - when unsigned_op=1: no abs/negate, sq=sr=0 (DIVU semantics); ZDIV behaviour is unchanged
//  Undefined: the port is absent and every operation is signed.
// STRUCTURE
//  Shared package: state encodings (IDLE, ITER, FIX, ZDIV), WIDTH default, ALL_ONES constant.
//  Package constants are shared with the multiplier and the control unit.
//  Sub-module divider_step (combinational): inputs R, Q, |B|; outputs the next R and Q for one
//  restoring iteration. It is instantiated once; the top holds the FSM, counter and sign fix.
// TESTING
//  1 A=100, B=7, start -> 33 cycles later done=1, Lo=14, Hi=2, div0=0; busy low again.
//  2 A=-100, B=7 -> Lo=32'hFFFFFFF2 (-14), Hi=32'hFFFFFFFE (-2).
//    A=100, B=-7 -> Lo=-14, Hi=2.
//  3 A=32'h80000000, B=-1 -> Lo=32'h80000000, Hi=0.
//    A=7, B=100 -> Lo=0, Hi=7.
//  4 A=5, B=0 -> done one cycle after start, div0=1, Hi=5, Lo=32'hFFFFFFFF.
//    div0 clears on the next start.
//  5 reset low at ITER cycle 10 -> all outputs 0 immediately (async).
//    Release, then A=9, B=3 -> Lo=3, Hi=0 after 33 cycles.
//  6 start A=50, B=5, then start A=81, B=9 at cycle 5 -> single done at 33 cycles after
//    the second start with Lo=9, Hi=0.
//    With DIVIDER_UNSIGNED_EN: unsigned_op=1, A=32'hFFFFFFFE, B=2 -> Lo=32'h7FFFFFFF, Hi=0.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared MULT/DIV constants: state encodings, default width and all-ones pattern.
package divider_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    ZDIV = 2'd3
  } div_state_e;

endpackage

// File: rtl/divider_step.sv
// One restoring division iteration: shift {r,q} left, subtract divisor if it fits.
module divider_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH:0]   b,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [2*WIDTH:0] rq_sh;
  logic [WIDTH:0]   r_sh;

  assign rq_sh = {r, q} << 1;
  assign r_sh  = rq_sh[2*WIDTH:WIDTH];

  // Trial subtraction; the quotient bit records whether it succeeded.
  always_comb begin
    r_next = r_sh;
    q_next = rq_sh[WIDTH-1:0];
    if (r_sh >= b) begin
      r_next    = r_sh - b;
      q_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/divider.sv
// Multi-cycle signed restoring divider (MIPS DIV: Lo=quotient, Hi=remainder).
// Optional DIVIDER_UNSIGNED_EN adds unsigned_op for DIVU semantics.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef DIVIDER_UNSIGNED_EN
  input  logic             unsigned_op,
`endif
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  div_state_e       state;
  logic [CNT_W-1:0] counter;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH:0]   b_mag;
  logic [WIDTH-1:0] a_raw;
  logic             sq;
  logic             sr;

  logic             uns;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_lo;

`ifdef DIVIDER_UNSIGNED_EN
  assign uns = unsigned_op;
`else
  assign uns = 1'b0;
`endif

  // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) as an unsigned value.
  assign neg_a = A[WIDTH-1] & ~uns;
  assign neg_b = B[WIDTH-1] & ~uns;
  assign abs_a = neg_a ? -A : A;
  assign abs_b = neg_b ? -B : B;
  assign r_lo  = r_q[WIDTH-1:0];

  divider_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .q      (q_q),
    .b      (b_mag),
    .r_next (r_next),
    .q_next (q_next)
  );

  // Control FSM and datapath registers; a start always wins and restarts the op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
      r_q     <= '0;
      q_q     <= '0;
      b_mag   <= '0;
      a_raw   <= '0;
      sq      <= 1'b0;
      sr      <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      div0    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_raw   <= A;
        q_q     <= abs_a;
        b_mag   <= {1'b0, abs_b};
        sq      <= neg_a ^ neg_b;
        sr      <= neg_a;
        r_q     <= '0;
        counter <= CNT_W'(WIDTH);
        div0    <= 1'b0;
        busy    <= 1'b1;
        state   <= (B == '0) ? ZDIV : ITER;
      end else begin
        case (state)
          IDLE: begin
          end
          ITER: begin
            r_q     <= r_next;
            q_q     <= q_next;
            counter <= counter - CNT_W'(1);
            if (counter == CNT_W'(1)) state <= FIX;
          end
          FIX: begin
            Lo    <= sq ? -q_q : q_q;
            Hi    <= sr ? -r_lo : r_lo;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          ZDIV: begin
            Hi    <= a_raw;
            Lo    <= WIDTH'(ALL_ONES);
            div0  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
